// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and reset constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    TRAP  = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the imem handshake, decode-side outputs and execute-side resolution inputs.
// Latency: n/a (wiring only).
// Backpressure: imem_req held until imem_valid; instruction held until retire.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [24:0] imm_field;
  logic [31:0] ext;
  logic [31:0] rs1;
  logic        br_taken;
  logic        jump;
  logic        jalr;
  logic        retire;
  logic        misalign;
  logic [31:0] retired_cnt;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, imm_field, misalign, retired_cnt,
    input  imem_valid, imem_rdata, ext, rs1, br_taken, jump, jalr, retire
  );

  // Memory / decode / execute side
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, imm_field, misalign, retired_cnt,
    output imem_valid, imem_rdata, ext, rs1, br_taken, jump, jalr, retire
  );
endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC selection: jalr > jump/branch > sequential, plus 4-byte alignment flag.
// Latency: purely combinational.
// Backpressure: none.
module next_pc_calc (
  input  logic [31:0] pc_i,
  input  logic [31:0] ext_i,
  input  logic [31:0] rs1_i,
  input  logic        jalr_i,
  input  logic        jump_i,
  input  logic        br_taken_i,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  // Priority-select the target; all sums wrap modulo 2^32.
  always_comb begin
    target_o = pc_i + 32'd4;
    if (jalr_i) begin
      target_o = (rs1_i + ext_i) & ~32'h1;
    end else if (jump_i || br_taken_i) begin
      target_o = pc_i + ext_i;
    end
    // No compressed ISA: any nonzero low bit pair is a fault, including jalr bit1.
    misaligned_o = (target_o[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC, fetches via req/valid, holds instr for execute until retire.
// Latency: 1 cycle minimum from imem_req to instr_valid; 2 cycles per instruction minimum.
// Backpressure: imem_req held (address stable) until imem_valid; instr held until retire.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         misalign_q, misalign_d;

  logic [31:0]  target;
  logic         target_misaligned;

  // Control inputs are only acted upon in the retire cycle, so they can feed the calc directly.
  next_pc_calc u_next_pc (
    .pc_i         (pc_q),
    .ext_i        (bus.ext),
    .rs1_i        (bus.rs1),
    .jalr_i       (bus.jalr),
    .jump_i       (bus.jump),
    .br_taken_i   (bus.br_taken),
    .target_o     (target),
    .misaligned_o (target_misaligned)
  );

  // State and datapath registers; reset is asynchronous so a mid-fetch reset drops everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      cnt_q      <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state logic; inputs that belong to another state are simply never looked at.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (bus.imem_valid) begin
          instr_d = bus.imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (bus.retire) begin
          // A trapping instruction still counts as retired.
          cnt_d = cnt_q + 32'd1;
          if (target_misaligned) begin
            misalign_d = 1'b1;
            state_d    = TRAP;
          end else begin
            pc_d    = target;
            state_d = FETCH;
          end
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == EXEC);
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;
  assign bus.imm_field   = instr_q[31:7];
  assign bus.misalign    = misalign_q;
  assign bus.retired_cnt = cnt_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Multi-cycle instruction fetch stage for the RISC-V core. It owns the program counter, fetches instructions from instruction memory through a request/valid handshake, and presents the held instruction and its immediate field to decode and the immediate unit. It consumes the sign-extended immediate returned by the immediate unit, plus branch/jump resolution, to compute the next PC when the current instruction retires.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_req  out  1  fetch request; held high until imem_valid.
- imem_addr  out  32  fetch address; equals pc while imem_req is high.
- imem_valid  in  1  imem_rdata is valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  held instruction.
- instr_valid  out  1  instr, pc and imm_field are valid for execute.
- pc  out  32  address of the held instruction.
- imm_field  out  25  instr[31:7], fed to the immediate unit.
- ext  in  32  sign-extended immediate from the immediate unit.
- rs1  in  32  register rs1 value, used for JALR.
- br_taken  in  1  conditional branch resolved taken.
- jump  in  1  JAL.
- jalr  in  1  JALR.
- retire  in  1  execute has consumed the held instruction.
- misalign  out  1  sticky: retired target was not 4-byte aligned.
- retired_cnt  out  32  count of retired instructions.

## Operation
- States: IDLE, FETCH, EXEC, TRAP.
- IDLE: entered on reset. Moves to FETCH unconditionally on the next edge.
- FETCH: imem_req=1. On imem_valid, imem_rdata is latched into instr and the state moves to EXEC. Otherwise the state holds.
- EXEC: instr_valid=1. On retire:
  - Compute target and increment retired_cnt.
  - If target[1:0]==0: load pc<=target and move to FETCH.
  - Otherwise: set misalign=1, keep pc, and move to TRAP.
- TRAP: every output is held, imem_req=0, instr_valid=0. Only rst_n exits this state.
- Target priority: jalr, then jump, then br_taken, then sequential.
  - jalr: (rs1+ext) & ~32'h1.
  - jump or br_taken: pc+ext.
  - sequential: pc+4.
- Arithmetic is 32-bit modulo 2^32. pc+4 from 32'hFFFF_FFFC wraps to 0. Overflow in ext addition wraps silently.
- Alignment is checked on bits [1:0]; no compressed-instruction support. A JALR target with bit1=1 traps.
- The trapping instruction counts as retired.
- retired_cnt wraps from 32'hFFFF_FFFF to 0.
- Inputs are ignored outside their own state:
  - retire outside EXEC.
  - imem_valid outside FETCH.
  - br_taken, jump, jalr, rs1 and ext are sampled only in the cycle retire is high.
- imm_field is combinationally instr[31:7] at all times.

## Timing
- Reset values:
  - pc=RESET_PC, instr=32'h0000_0013 (NOP), retired_cnt=0, misalign=0.
  - instr_valid=0, imem_req=0, state=IDLE.
- First imem_req is high in the first cycle after rst_n deasserts.
- With imem_valid in the same cycle as imem_req, instr_valid rises on the next cycle. Minimum fetch latency is 1 cycle; minimum throughput is 2 cycles per instruction.
- retire high in cycle N (EXEC): instr_valid=0 and imem_req=1 with the new imem_addr in cycle N+1.
- imem_addr stays stable while imem_req is high and imem_valid is low.
- Reset asserted mid-fetch or mid-EXEC: all state returns to reset values immediately. Any imem_valid arriving afterwards is dropped.

## Structure
- Shared package riscv_pkg:
  - fetch_state_t enum (IDLE, FETCH, EXEC, TRAP).
  - NOP_INSTR constant (32'h0000_0013).
  - DEFAULT_RESET_PC constant.
- One combinational sub-module, next_pc_calc. Inputs: pc, ext, rs1, jalr, jump, br_taken. Outputs: target, misaligned.
- fetch_unit holds the FSM, registers and counter.

## Test plan
- Reset release, imem_valid immediate, retire with no control inputs → imem_addr sequence 0, 4, 8; retired_cnt 1, 2.
- imem_valid delayed 3 cycles → imem_addr stable at 0x4 throughout the wait; instr_valid rises exactly 1 cycle after imem_valid.
- pc=0x100, ext=0xFFFF_FFF0, br_taken=1 → next imem_addr=0xF0. Same inputs with jalr=1, rs1=0x201 → next imem_addr=0x1F0 (jalr priority).
- pc=0x100, jump=1, ext=0x2 → misalign=1, state TRAP, imem_req stays 0, pc stays 0x100, retired_cnt increments once.
- pc=0xFFFF_FFFC, sequential retire → imem_addr wraps to 0. rst_n pulsed mid-FETCH → pc=RESET_PC, a late imem_valid is ignored.
- retire and imem_valid pulsed while in FETCH/EXEC respectively → no state or counter change.
